// File: rtl/accel_host_seq_if.sv
// Host-sequencer bundle: job control, input/result streams, accel port.
// master = sequencer side (drives accel bus), slave = environment side.
interface accel_host_seq_if;
    logic        go;
    logic        busy;
    logic        done;
    logic        err;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        acc_wen;
    logic        acc_start;
    logic [31:0] acc_addr;
    logic [31:0] acc_din;
    logic [31:0] acc_dout;
    logic        acc_bsy;

    modport master (
        input  go, in_valid, in_data, out_ready,
        input  acc_dout, acc_bsy,
        output busy, done, err, in_ready,
        output out_valid, out_data,
        output acc_wen, acc_start, acc_addr, acc_din
    );

    modport slave (
        output go, in_valid, in_data, out_ready,
        output acc_dout, acc_bsy,
        input  busy, done, err, in_ready,
        input  out_valid, out_data,
        input  acc_wen, acc_start, acc_addr, acc_din
    );
endinterface

// File: rtl/accel_host_seq.sv
// Sequencer: streams DEPTH words into the accelerator, starts it, waits on
// bsy (with timeout), reads DEPTH results back out. Ports: clk, rst_n, bus.
module accel_host_seq #(
    parameter int DEPTH   = 32,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    accel_host_seq_if.master bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_TO  = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, KICK, WAIT_HI, WAIT_LO,
        RD_ADDR, RD_WAIT, RD_HOLD, FIN
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] tcnt;
    logic [LW-1:0] lcnt;
    logic [31:0]   din_q;
    logic [31:0]   out_q;
    logic          err_q;

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.err       = err_q;
    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == RD_HOLD);
    assign bus.out_data  = out_q;
    assign bus.acc_start = (state == KICK);
    assign bus.acc_wen   = (state == LOAD) && bus.in_valid;
    assign bus.acc_addr  = {{(30 - IW){1'b0}}, idx, 2'b00};
    // Write data passes straight through while loading and otherwise
    // holds the last word written.
    assign bus.acc_din   = (state == LOAD) ? bus.in_data : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
            lcnt  <= '0;
            din_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.go) begin
                        err_q <= 1'b0;
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        din_q <= bus.in_data;
                        // idx stays at the last word so the address
                        // never runs past the buffer
                        if (idx == LAST_IDX) begin
                            state <= KICK;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                KICK: begin
                    tcnt  <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.acc_bsy) begin
                        tcnt  <= tcnt + CW'(1);
                        state <= WAIT_LO;
                    end else if (tcnt >= LAST_TO) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                WAIT_LO: begin
                    // completion beats a simultaneous timeout
                    if (!bus.acc_bsy) begin
                        idx   <= '0;
                        state <= RD_ADDR;
                    end else if (tcnt >= LAST_TO) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RD_ADDR: begin
                    lcnt  <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lcnt == LAST_LAT) begin
                        out_q <= bus.acc_dout;
                        state <= RD_HOLD;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                RD_HOLD: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= RD_ADDR;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accel_host_seq.sv
// Bench for accel_host_seq: two instances (RD_LAT 1 / TIMEOUT 1023 and
// RD_LAT 3 / TIMEOUT 15) against a behavioural x^3 accelerator.
module tb_accel_host_seq;
    localparam int D     = 32;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nbad = 0;
    logic [31:0] exp_q [$];

    logic [1:0]       go_s  = '0;
    logic [1:0]       iv_s  = '0;
    logic [1:0]       or_s  = '0;
    logic [1:0]       nobsy = '0;
    logic [1:0][31:0] id_s  = '0;

    logic [1:0]       busy_s, done_s, err_s, ir_s, ov_s, wen_s, st_s;
    logic [1:0][31:0] od_s, addr_s, din_s, dout_s;
    logic [1:0]       bsy_s = '0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        accel_host_seq_if bus ();
        assign bus.go        = go_s[g];
        assign bus.in_valid  = iv_s[g];
        assign bus.in_data   = id_s[g];
        assign bus.out_ready = or_s[g];
        assign bus.acc_dout  = dout_s[g];
        assign bus.acc_bsy   = bsy_s[g];
        assign busy_s[g]     = bus.busy;
        assign done_s[g]     = bus.done;
        assign err_s[g]      = bus.err;
        assign ir_s[g]       = bus.in_ready;
        assign ov_s[g]       = bus.out_valid;
        assign od_s[g]       = bus.out_data;
        assign wen_s[g]      = bus.acc_wen;
        assign st_s[g]       = bus.acc_start;
        assign addr_s[g]     = bus.acc_addr;
        assign din_s[g]      = bus.acc_din;

        accel_host_seq #(
            .DEPTH  (D),
            .RD_LAT (g ? 3 : 1),
            .TIMEOUT(g ? 15 : 1023)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    // ---------------- accelerator model ----------------
    function automatic logic [31:0] cube(input logic [31:0] x);
        logic [63:0] d;
        logic [7:0]  e8;
        real         r;
        if (x[30:0] == 31'd0) return x;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        r = $bitstoreal(d);
        r = r * r * r;
        d = $realtobits(r);
        e8 = 8'(d[62:52] - 11'd896);
        return {d[63], e8, d[51:29]};
    endfunction

    logic [31:0] mem [2][D];
    logic [4:0]  ap  [2][3];
    int          bcnt [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wen_s[k]) mem[k][addr_s[k][6:2]] <= cube(din_s[k]);
            ap[k][0] <= addr_s[k][6:2];
            ap[k][1] <= ap[k][0];
            ap[k][2] <= ap[k][1];
            if (st_s[k]) begin
                bsy_s[k] <= !nobsy[k];
                bcnt[k]  <= (k == 1) ? 5 : 279;
            end else if (bcnt[k] != 0) begin
                bcnt[k] <= bcnt[k] - 1;
            end else begin
                bsy_s[k] <= 1'b0;
            end
        end
    end

    assign dout_s[0] = mem[0][ap[0][0]];
    assign dout_s[1] = mem[1][ap[1][2]];

    // ---------------- bus monitor ----------------
    int widx [2], wcnt [2], wbad [2];
    int st_cnt [2], st_cyc [2], dn_cnt [2], ld_cnt [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!busy_s[k]) widx[k] = 0;
            if (wen_s[k]) begin
                if (addr_s[k] !== 32'(widx[k] << 2)) wbad[k]++;
                widx[k]++;
                wcnt[k]++;
            end
            if (wen_s[k] && st_s[k]) wbad[k]++;
            if (addr_s[k] > 32'h7C) wbad[k]++;
            if (st_s[k]) begin
                st_cnt[k]++;
                st_cyc[k] = cyc;
            end
            if (done_s[k]) dn_cnt[k]++;
            if (ir_s[k]) ld_cnt[k]++;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dexp;
        int          inst;
        bit          uni;
        bit          stall;
        int          bpw;
        bit          gow;
    } vec_t;

    vec_t tbl [6];

    task automatic build(input int r, output logic [31:0] w [D],
                         output logic [31:0] e [D]);
        for (int i = 0; i < D; i++) begin
            int j;
            j = tbl[r].uni ? r : (r + i) % 6;
            w[i] = tbl[j].din;
            e[i] = tbl[j].dexp;
        end
    endtask

    task automatic pulse_go(input int k);
        @(negedge clk);
        go_s[k] = 1'b1;
        @(negedge clk);
        go_s[k] = 1'b0;
    endtask

    task automatic feed(input int k, input logic [31:0] w [D],
                        input bit stall);
        int i = 0;
        int t = 0;
        bit tog = 1'b1;
        while (i < D && t < BOUND) begin
            iv_s[k] = stall ? tog : 1'b1;
            id_s[k] = w[i];
            if (iv_s[k] && ir_s[k]) i++;
            tog = !tog;
            t++;
            @(negedge clk);
        end
        iv_s[k] = 1'b0;
    endtask

    task automatic run_job(input int k, input logic [31:0] w [D],
                           input logic [31:0] e [D], input bit stall,
                           input int bpw, input int rstw, input bit gow);
        int d0, s0, wc0, wb0, l0, gap, gap_bad, stable_bad, last_hs;
        bit aborted;
        d0 = dn_cnt[k];
        s0 = st_cnt[k];
        wc0 = wcnt[k];
        wb0 = wbad[k];
        l0 = ld_cnt[k];
        gap = (k == 1) ? 5 : 3;
        gap_bad = 0;
        stable_bad = 0;
        last_hs = -1;
        aborted = 1'b0;
        for (int i = 0; i < D; i++) exp_q.push_back(e[i]);
        pulse_go(k);
        check("err_clr", 32'(err_s[k]), 0);
        fork
            feed(k, w, stall);
            begin
                for (int wd = 0; wd < D; wd++) begin
                    int t = 0;
                    logic [31:0] hold;
                    while (!ov_s[k] && t < BOUND) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!ov_s[k]) begin
                        check("out_valid_wait", 32'(ov_s[k]), 1);
                        aborted = 1'b1;
                        break;
                    end
                    if (wd == rstw) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_busy", 32'(busy_s[k]), 0);
                        check("rst_ovalid", 32'(ov_s[k]), 0);
                        check("rst_odata", od_s[k], 0);
                        check("rst_addr", addr_s[k], 0);
                        check("rst_din", din_s[k], 0);
                        check("rst_wen", 32'(wen_s[k]), 0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        aborted = 1'b1;
                        break;
                    end
                    if (wd == bpw) begin
                        hold = od_s[k];
                        repeat (4) begin
                            @(negedge clk);
                            if (od_s[k] !== hold) stable_bad++;
                            if (addr_s[k] !== 32'(wd << 2)) stable_bad++;
                            if (!ov_s[k]) stable_bad++;
                        end
                    end
                    if (last_hs >= 0 && wd != bpw && cyc - last_hs != gap)
                        gap_bad++;
                    or_s[k] = 1'b1;
                    if (exp_q.size() != 0)
                        check("out_data", od_s[k], exp_q.pop_front());
                    else
                        check("sb_underflow", exp_q.size(), 1);
                    last_hs = cyc;
                    @(negedge clk);
                    or_s[k] = 1'b0;
                    if (wd == D - 1)
                        check("done_pulse", 32'(done_s[k]), 1);
                end
            end
            begin
                if (gow) begin
                    int t = 0;
                    while (!bsy_s[k] && t < BOUND) begin
                        @(negedge clk);
                        t++;
                    end
                    pulse_go(k);
                end
            end
        join
        if (aborted) begin
            exp_q.delete();
            repeat (2) @(negedge clk);
            return;
        end
        repeat (3) @(negedge clk);
        check("done_cnt", dn_cnt[k] - d0, 1);
        check("start_cnt", st_cnt[k] - s0, 1);
        check("wr_cnt", wcnt[k] - wc0, D);
        check("wr_order", wbad[k] - wb0, 0);
        check("load_cyc", ld_cnt[k] - l0, stall ? 63 : 32);
        check("err_end", 32'(err_s[k]), 0);
        check("busy_end", 32'(busy_s[k]), 0);
        check("rd_gap", gap_bad, 0);
        if (bpw >= 0) check("bp_stable", stable_bad, 0);
        check("sb_left", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w [D];
        logic [31:0] e [D];
        int d0, s0, n;

        tbl[0] = '{32'h40000000, 32'h41000000, 0, 1'b1, 1'b0, -1, 1'b0};
        tbl[1] = '{32'h3F800000, 32'h3F800000, 0, 1'b0, 1'b1, -1, 1'b0};
        tbl[2] = '{32'h40400000, 32'h41D80000, 0, 1'b0, 1'b0,  7, 1'b0};
        tbl[3] = '{32'hC0000000, 32'hC1000000, 0, 1'b0, 1'b0, -1, 1'b1};
        tbl[4] = '{32'h3F000000, 32'h3E000000, 1, 1'b0, 1'b0, -1, 1'b0};
        tbl[5] = '{32'h3FC00000, 32'h40580000, 1, 1'b0, 1'b1,  7, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(busy_s[0]), 0);
        check("rst_done0", 32'(done_s[0]), 0);
        check("rst_err0", 32'(err_s[0]), 0);
        check("rst_iready0", 32'(ir_s[0]), 0);
        check("rst_ovalid0", 32'(ov_s[0]), 0);
        check("rst_odata0", od_s[0], 0);
        check("rst_wen0", 32'(wen_s[0]), 0);
        check("rst_start0", 32'(st_s[0]), 0);
        check("rst_addr0", addr_s[0], 0);
        check("rst_din0", din_s[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            build(r, w, e);
            run_job(tbl[r].inst, w, e, tbl[r].stall,
                    tbl[r].bpw, -1, tbl[r].gow);
        end

        // timeout on the TIMEOUT=15 instance: bsy never rises
        nobsy[1] = 1'b1;
        d0 = dn_cnt[1];
        s0 = st_cnt[1];
        build(4, w, e);
        pulse_go(1);
        feed(1, w, 1'b0);
        n = 0;
        while (busy_s[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_idle", 32'(busy_s[1]), 0);
        check("to_err", 32'(err_s[1]), 1);
        check("to_cycles", cyc - st_cyc[1], 16);
        check("to_start", st_cnt[1] - s0, 1);
        repeat (5) @(negedge clk);
        check("to_sticky", 32'(err_s[1]), 1);
        check("to_nodone", dn_cnt[1] - d0, 0);
        nobsy[1] = 1'b0;
        build(1, w, e);
        run_job(1, w, e, 1'b0, -1, -1, 1'b0);

        // reset during readback, then a clean job
        build(2, w, e);
        run_job(0, w, e, 1'b0, -1, 10, 1'b0);
        build(3, w, e);
        run_job(0, w, e, 1'b0, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nchk, nbad);
        $finish;
    end
endmodule

// File: doc/accel_host_seq.md
# accel_host_seq

Host-side sequencer that drives the accelerator's memory-mapped command port end to end. It streams DEPTH input words into accelerator memory, pulses start, waits for bsy to fall, then reads DEPTH result words back out as a stream. It sits between the testbench or SoC data source and the accelerator, and owns every transaction on wen/start/addr/din.

## Interface
- DEPTH, 32: words per job, 2..64; index width IW = clog2(DEPTH).
- RD_LAT, 1: accelerator read latency in cycles, from address presented to acc_dout valid; range 1..4.
- TIMEOUT, 1023: maximum cycles spent waiting on bsy (rise plus fall) before abort.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- go  in  1  job request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE; reset 0.
- done  out  1  one-cycle pulse on job completion; reset 0.
- err  out  1  sticky timeout flag, cleared by the next accepted go; reset 0.
- in_valid / in_ready  in / out  1 / 1  input stream handshake; in_ready resets to 0.
- in_data  in  32  input word, IEEE-754 single precision.
- out_valid / out_ready  out / in  1 / 1  result stream handshake; out_valid resets to 0.
- out_data  out  32  result word; reset 0.
- acc_wen  out  1  accelerator write enable; reset 0.
- acc_start  out  1  accelerator start pulse; reset 0.
- acc_addr  out  32  byte address = idx<<2, bits [1:0] always 0; reset 0.
- acc_din  out  32  accelerator write data; reset 0.
- acc_dout  in  32  accelerator read data.
- acc_bsy  in  1  accelerator busy.

## Operation
- The FSM has nine states: IDLE, LOAD, KICK, WAIT_HI, WAIT_LO, RD_ADDR, RD_WAIT, RD_HOLD, FIN.
- IDLE: if go=1, clear err and idx, then go to LOAD.
- LOAD: in_ready=1. acc_wen=in_valid, acc_din=in_data, acc_addr=idx<<2, all combinational from state, idx and inputs.
  - Each accepted word increments idx.
  - After the word with idx=DEPTH-1 is accepted, go to KICK.
  - in_valid=0 stalls the FSM with acc_wen=0.
- KICK: acc_start=1 for exactly one cycle, acc_wen=0, then go to WAIT_HI. The timeout counter clears on KICK.
- WAIT_HI: wait for acc_bsy=1, then go to WAIT_LO.
- WAIT_LO: wait for acc_bsy=0, then clear idx and go to RD_ADDR.
- Timeout: the counter increments in WAIT_HI and WAIT_LO. When it reaches TIMEOUT, set err=1 and go to IDLE with no done pulse.
- Outside LOAD, acc_wen=0 at all times. acc_din is don't-care but is held at its last value.
- RD_ADDR: acc_addr=idx<<2, acc_wen=0, one cycle, then go to RD_WAIT.
- RD_WAIT: hold acc_addr for RD_LAT cycles. On the last of these cycles, register acc_dout into out_data, then go to RD_HOLD.
- RD_HOLD: out_valid=1 and out_data stays stable until out_ready=1.
  - On that handshake, if idx=DEPTH-1 go to FIN; otherwise increment idx and go to RD_ADDR.
  - Only one read is ever outstanding.
- FIN: done=1 for one cycle, then go to IDLE.
- go asserted outside IDLE is ignored, with no queueing.
- Reset mid-job: all outputs return to their reset values immediately and the FSM enters IDLE. Accelerator state is not recovered; the next job rewrites all DEPTH words.

## Timing
- Cycle 0 is the edge that samples go=1. LOAD is active from cycle 1.
- With in_valid held high, the words are written in cycles 1..DEPTH, KICK occurs at cycle DEPTH+1, and WAIT_HI starts at cycle DEPTH+2.
- acc_bsy from the accelerator rises one cycle after acc_start, so WAIT_HI normally lasts 1 cycle.
- Per result word: RD_ADDR takes 1 cycle, RD_WAIT takes RD_LAT cycles, and out_valid is first high on cycle 2+RD_LAT after RD_ADDR starts.
- With out_ready held high, the read throughput is one word per RD_LAT+2 cycles.
- done is asserted the cycle after the final out handshake.
- acc_start and acc_wen are never high in the same cycle.
- acc_addr never exceeds (DEPTH-1)<<2.
- If acc_bsy is already 1 at KICK, WAIT_HI exits on the next cycle; this is legal.
- If acc_bsy falls on the same cycle the timeout counter reaches TIMEOUT, the completion wins: go to RD_ADDR and leave err at 0.

## Test plan
- Nominal job: DEPTH=32, RD_LAT=1, behavioural accelerator model computing x³. Input all 0x40000000 (2.0) with go pulsed, busy 280 cycles -> 32 writes to addresses 0x00..0x7C, one acc_start pulse, 32 outputs of 0x41000000 (8.0), one done pulse, err=0.
- Input stalls: in_valid toggling 1-0-1 each cycle -> acc_wen mirrors in_valid, no address skipped or repeated, 32 writes in 63 cycles.
- Output backpressure: out_ready low for 5 cycles on word 7 -> out_data stays stable, acc_addr stays 0x1C, word order is preserved.
- Timeout: model never asserts acc_bsy, TIMEOUT=15 -> err=1 after 15 wait cycles, FSM in IDLE, no done pulse. The next go clears err.
- Reset mid-read: rst_n low at word 10 of readback -> all outputs 0 within the same cycle. A new job then completes with correct data.
- Ignored go: pulse go during WAIT_LO -> no effect, exactly one done pulse; RD_LAT=3 rerun gives 5 cycles per word.
